// File: rtl/fp_result_serializer.sv
// Snapshots a frame of FP multiply/accumulate results and streams it out one word per valid/ready beat.
// Optional feature: define FP_RES_HDR_EN to prefix every frame with a header word.
module fp_result_serializer #(
    parameter int NUM_PAIRS = 8,
    parameter int WORD_W    = 32,
    parameter int CNT_W     = 16
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic [2*NUM_PAIRS*WORD_W-1:0]   in_results,
    input  logic                            in_sendable,
    input  logic                            in_save_sign,
    input  logic                            in_acc_sign,
    input  logic                            clr_overrun,
    output logic [WORD_W-1:0]               m_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic                            m_last,
    output logic                            busy,
    output logic                            frame_acc_sign,
    output logic [CNT_W-1:0]                frame_cnt,
    output logic                            overrun,
    output logic [CNT_W-1:0]                overrun_cnt
);

    localparam int NUM_WORDS = 2 * NUM_PAIRS;
`ifdef FP_RES_HDR_EN
    localparam int HDR_WORDS = 1;
`else
    localparam int HDR_WORDS = 0;
`endif
    localparam int FRAME_LEN = NUM_WORDS + HDR_WORDS;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int SEL_W     = $clog2(NUM_WORDS);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state;
    state_t              state_next;
    logic [WORD_W-1:0]   buffer [NUM_WORDS];
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_next;
    logic [SEL_W-1:0]    word_sel;
    logic                save_d;
    logic                req;
    logic                last_beat;
    logic                capture;
    logic                finish;
    logic                ovr_evt;

    assign req       = in_save_sign & ~save_d & in_sendable;
    assign ovr_evt   = req & (state == SEND);
    assign last_beat = (idx == IDX_W'(FRAME_LEN - 1));
    assign word_sel  = SEL_W'(idx - IDX_W'(HDR_WORDS));

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        capture    = 1'b0;
        finish     = 1'b0;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        m_data     = '0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    capture    = 1'b1;
                    idx_next   = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                m_valid = 1'b1;
                busy    = 1'b1;
                m_last  = last_beat;
`ifdef FP_RES_HDR_EN
                // Header reports the count of frames completed before this one.
                if (idx == '0)
                    m_data = WORD_W'({16'hA5C3, 7'd0, frame_acc_sign, frame_cnt[7:0]});
                else
                    m_data = buffer[word_sel];
`else
                m_data = buffer[word_sel];
`endif
                if (m_ready) begin
                    if (last_beat) begin
                        finish     = 1'b1;
                        idx_next   = '0;
                        state_next = IDLE;
                    end else begin
                        idx_next = idx + IDX_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Buffer only loads from IDLE, so a request during a send never disturbs it.
    always_ff @(posedge aclk) begin
        if (capture) begin
            for (int k = 0; k < NUM_WORDS; k++)
                buffer[k] <= in_results[k*WORD_W +: WORD_W];
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            save_d         <= 1'b0;
            frame_acc_sign <= 1'b0;
            frame_cnt      <= '0;
            overrun        <= 1'b0;
            overrun_cnt    <= '0;
        end else begin
            save_d <= in_save_sign;
            if (capture)
                frame_acc_sign <= in_acc_sign;
            if (finish)
                frame_cnt <= frame_cnt + CNT_W'(1);
            if (ovr_evt)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
            if (ovr_evt && (overrun_cnt != '1))
                overrun_cnt <= overrun_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fp_result_serializer.sv
// Directed self-checking bench for fp_result_serializer; honours FP_RES_HDR_EN for header frames.
`timescale 1ns/1ps
module tb_fp_result_serializer;

    localparam int NUM_PAIRS = 8;
    localparam int WORD_W    = 32;
    localparam int CNT_W     = 16;
    localparam int NUM_WORDS = 2 * NUM_PAIRS;
`ifdef FP_RES_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int FRAME_LEN = NUM_WORDS + HDR;
    localparam logic [31:0] BASE = 32'h3F800000;

    logic                          aclk;
    logic                          areset;
    logic [2*NUM_PAIRS*WORD_W-1:0] in_results;
    logic                          in_sendable;
    logic                          in_save_sign;
    logic                          in_acc_sign;
    logic                          clr_overrun;
    logic [WORD_W-1:0]             m_data;
    logic                          m_valid;
    logic                          m_ready;
    logic                          m_last;
    logic                          busy;
    logic                          frame_acc_sign;
    logic [CNT_W-1:0]              frame_cnt;
    logic                          overrun;
    logic [CNT_W-1:0]              overrun_cnt;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] exp_frames;
    logic             exp_acc;

    fp_result_serializer #(
        .NUM_PAIRS(NUM_PAIRS),
        .WORD_W   (WORD_W),
        .CNT_W    (CNT_W)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .in_results    (in_results),
        .in_sendable   (in_sendable),
        .in_save_sign  (in_save_sign),
        .in_acc_sign   (in_acc_sign),
        .clr_overrun   (clr_overrun),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .busy          (busy),
        .frame_acc_sign(frame_acc_sign),
        .frame_cnt     (frame_cnt),
        .overrun       (overrun),
        .overrun_cnt   (overrun_cnt)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] base, input bit bad);
        for (int k = 0; k < NUM_WORDS; k++)
            in_results[k*WORD_W +: WORD_W] = bad ? 32'hDEADBEEF : base + 32'(k);
    endtask

    function automatic logic [31:0] exp_word(input int beat);
        if (HDR == 1 && beat == 0)
            return {16'hA5C3, 7'd0, exp_acc, exp_frames[7:0]};
        return BASE + 32'(beat - HDR);
    endfunction

    task automatic request();
        checkOutput("idle_before_req", {31'd0, m_valid}, 32'd0);
        in_save_sign = 1'b1;
        exp_acc      = in_acc_sign;
        step();
        in_save_sign = 1'b0;
        checkOutput("valid_latency", {31'd0, m_valid}, 32'd1);
        checkOutput("busy_on", {31'd0, busy}, 32'd1);
        checkOutput("acc_latched", {31'd0, frame_acc_sign}, {31'd0, exp_acc});
    endtask

    // ovr_beat < 0 disables the mid-frame overrun request.
    task automatic receive_frame(input bit bp, input int ovr_beat);
        int beat = 0;
        int cyc  = 0;
        bit ovr_done = 0;
        logic [3:0] pat = 4'b1001;
        while (beat < FRAME_LEN && cyc < 200) begin
            m_ready      = bp ? pat[cyc[1:0]] : 1'b1;
            in_save_sign = 1'b0;
            if (beat == ovr_beat && !ovr_done) begin
                ovr_done     = 1;
                in_save_sign = 1'b1;
                applyStimulus(BASE, 1'b1);
            end
            checkOutput("m_valid_hold", {31'd0, m_valid}, 32'd1);
            checkOutput($sformatf("m_data_beat%0d", beat), m_data, exp_word(beat));
            checkOutput($sformatf("m_last_beat%0d", beat), {31'd0, m_last},
                        {31'd0, (beat == FRAME_LEN - 1)});
            if (m_valid && m_ready)
                beat++;
            step();
            cyc++;
        end
        in_save_sign = 1'b0;
        m_ready      = 1'b1;
        checkOutput("frame_complete", beat, FRAME_LEN);
        exp_frames = exp_frames + 1'b1;
        checkOutput("m_valid_end", {31'd0, m_valid}, 32'd0);
        checkOutput("busy_end", {31'd0, busy}, 32'd0);
        checkOutput("frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_frames});
    endtask

    task automatic pulse_reset();
        areset = 1'b1;
        step();
        areset     = 1'b0;
        exp_frames = '0;
    endtask

    initial begin
        areset       = 1'b1;
        in_results   = '0;
        in_sendable  = 1'b1;
        in_save_sign = 1'b0;
        in_acc_sign  = 1'b0;
        clr_overrun  = 1'b0;
        m_ready      = 1'b1;
        exp_frames   = '0;
        exp_acc      = 1'b0;
        step();
        step();
        checkOutput("rst_m_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("rst_m_last", {31'd0, m_last}, 32'd0);
        checkOutput("rst_m_data", m_data, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_acc", {31'd0, frame_acc_sign}, 32'd0);
        checkOutput("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("rst_overrun_cnt", {16'd0, overrun_cnt}, 32'd0);
        areset = 1'b0;
        step();

        $display("[TB] single frame");
        applyStimulus(BASE, 1'b0);
        request();
        receive_frame(1'b0, -1);

        $display("[TB] backpressure frame");
        in_acc_sign = 1'b1;
        applyStimulus(BASE, 1'b0);
        request();
        receive_frame(1'b1, -1);

        $display("[TB] overrun at beat 5");
        in_acc_sign = 1'b0;
        applyStimulus(BASE, 1'b0);
        request();
        receive_frame(1'b0, 5);
        checkOutput("overrun_set", {31'd0, overrun}, 32'd1);
        checkOutput("overrun_cnt1", {16'd0, overrun_cnt}, 32'd1);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        checkOutput("overrun_clr", {31'd0, overrun}, 32'd0);
        checkOutput("overrun_cnt_kept", {16'd0, overrun_cnt}, 32'd1);

        $display("[TB] overrun on last handshake");
        applyStimulus(BASE, 1'b0);
        request();
        receive_frame(1'b0, FRAME_LEN - 1);
        checkOutput("overrun_last", {31'd0, overrun}, 32'd1);
        checkOutput("overrun_cnt2", {16'd0, overrun_cnt}, 32'd2);
        step();
        checkOutput("no_capture_after_last", {31'd0, m_valid}, 32'd0);
        applyStimulus(BASE, 1'b0);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;

        $display("[TB] gated request");
        in_sendable  = 1'b0;
        in_save_sign = 1'b1;
        step();
        step();
        checkOutput("gated_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("gated_busy", {31'd0, busy}, 32'd0);
        checkOutput("gated_overrun", {31'd0, overrun}, 32'd0);
        in_sendable = 1'b1;
        step();
        step();
        checkOutput("held_level_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("held_level_busy", {31'd0, busy}, 32'd0);
        in_save_sign = 1'b0;
        step();

        $display("[TB] reset mid-frame");
        request();
        for (int b = 0; b < 3; b++) begin
            checkOutput($sformatf("mid_data%0d", b), m_data, exp_word(b));
            step();
        end
        areset = 1'b1;
        step();
        checkOutput("midrst_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("midrst_last", {31'd0, m_last}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        areset     = 1'b0;
        exp_frames = '0;
        step();
        request();
        receive_frame(1'b0, -1);

        $display("[TB] back-to-back frames");
        pulse_reset();
        in_acc_sign = 1'b1;
        request();
        receive_frame(1'b0, -1);
        request();
        receive_frame(1'b0, -1);
        checkOutput("b2b_frame_cnt", {16'd0, frame_cnt}, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
